serial_word_framer: RTL and testbench
=====================================

Name: serial_word_framer

Overview:
- Downstream consumer of the transmission-gate D flip-flop stage: takes the registered serial bit stream (one bit per qualified clk), deserialises it MSB-first and locks onto a sync word.
- Once locked, emits fixed-length payload frames as parallel words with valid/done strobes.
- Verifies that each frame is followed by the sync word; on mismatch drops lock and re-hunts bit-by-bit.

Parameters:
- WIDTH, 8, word width in bits; legal values >= 2.
- SYNC_WORD, 8'hA5, frame delimiter pattern, WIDTH bits.
- PAYLOAD_LEN, 4, payload words per frame; legal values >= 1.

Ports:
- clk  input  1  sampling clock, rising edge; same clock as the upstream flip-flop stage.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  bit-valid qualifier; din is sampled only when en=1.
- din  input  1  serial data (upstream Q), MSB first.
- dout  output  WIDTH  last completed payload word.
- dout_valid  output  1  one-cycle pulse, dout is new.
- frame_done  output  1  one-cycle pulse coincident with dout_valid of the last payload word.
- locked  output  1  high while frame-aligned.
- sync_err  output  1  one-cycle pulse, trailer word did not match SYNC_WORD.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-frame):
  - All outputs are 0, shift register is 0, state is HUNT.
  - Bit counter, word counter and fill counter are 0; partial frame is discarded.
- Shift register:
  - On a clk edge with en=1: sr <= {sr[WIDTH-2:0], din}.
  - nxt = {sr[WIDTH-2:0], din} denotes the value being shifted in.
  - en=0: all state holds; pulse outputs are 0.
- Fill guard: after reset, pattern detection is inhibited until WIDTH bits have been shifted in. The fill counter saturates at WIDTH.
- All outputs are registered. Strobes assert in the cycle after the edge that samples the completing bit and last exactly one cycle.
- HUNT:
  - Every en=1 edge with fill complete and nxt==SYNC_WORD -> PAYLOAD, locked<=1, bit_cnt<=0, word_cnt<=0.
  - Otherwise stays in HUNT; search slides one bit per en edge.
- PAYLOAD:
  - bit_cnt increments per en edge.
  - At bit_cnt==WIDTH-1: dout<=nxt, dout_valid<=1, bit_cnt<=0.
  - If word_cnt==PAYLOAD_LEN-1: frame_done<=1 and go to CHECK; else word_cnt++.
  - Payload words equal to SYNC_WORD are plain data with no effect on framing.
- CHECK:
  - Collects WIDTH bits. At bit_cnt==WIDTH-1:
  - nxt==SYNC_WORD -> PAYLOAD, word_cnt<=0, locked stays 1.
  - Otherwise sync_err<=1, locked<=0, go to HUNT. sr retains its contents and fill stays complete, so a sync straddling the bad trailer is found on subsequent bits.
- dout holds its last value between strobes and is not cleared on loss of lock.
- No strobe is ever asserted while in HUNT.
- Counter widths: bit_cnt is clog2(WIDTH) bits; word_cnt is clog2(PAYLOAD_LEN) bits with a minimum of 1 bit.

Test Plan:
Defaults WIDTH=8, SYNC_WORD=A5, PAYLOAD_LEN=4; en=1 unless stated; bit n is sampled at clk edge n.
- Reset: assert rst_n=0 between edges mid-payload -> dout=00 and locked/dout_valid/frame_done/sync_err=0 immediately, without a clk edge. After release, send A5 -> locked=1 after edge 8.
- Clean frame: send A5,11,22,33,44,A5 -> locked=1 after edge 8. dout_valid with dout=11,22,33,44 after edges 16,24,32,40. frame_done only with 44. No sync_err after edge 48; locked stays 1.
- Misalignment plus guard:
  - Send 3 bits 1,0,1 then A5 -> lock after edge 11, not before.
  - With a fresh reset, send 0xA5 starting at bit 1 -> lock after edge 8. No false match occurs during fill.
- Bad trailer: A5,11,22,33,44,5A -> sync_err pulse after edge 48 and locked=0. Then send A5,01,02,03,04 -> relock after edge 56; words 01..04 delivered.
- Qualifier gaps: clean-frame stream with en toggling 1,0,1,0 -> identical dout sequence at doubled timing. Strobes occur only after en=1 edges and are 0 during en=0 cycles.
- Sync inside payload: A5,A5,A5,A5,A5,A5 -> four payload words A5 delivered, then trailer A5 accepted; no sync_err, frame_done once.

Source files
------------

// File: rtl/serial_word_framer.sv
// Serial-to-parallel framer: hunts for SYNC_WORD MSB-first, then emits PAYLOAD_LEN words
// per frame and verifies that each frame is followed by another sync word.
module serial_word_framer #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hA5,
    parameter int               PAYLOAD_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             frame_done,
    output logic             locked,
    output logic             sync_err
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int FW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, nxt;
    logic [FW-1:0]    fill;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [CW-1:0]    word_cnt, word_n;
    logic [WIDTH-1:0] dout_n;
    logic             locked_n, dv_n, fd_n, se_n;
    logic             fill_ok, last_bit, match;

    assign nxt      = {sr[WIDTH-2:0], din};
    // The bit being sampled now counts toward the fill, so a sync landing
    // exactly on the WIDTH-th bit after reset is accepted.
    assign fill_ok  = (fill >= FW'(WIDTH - 1));
    assign last_bit = (bit_cnt == BW'(WIDTH - 1));
    assign match    = (nxt == SYNC_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            fill <= '0;
        end else if (en) begin
            sr <= nxt;
            if (fill != FW'(WIDTH)) fill <= fill + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            dout       <= '0;
            locked     <= 1'b0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_n;
            word_cnt   <= word_n;
            dout       <= dout_n;
            locked     <= locked_n;
            dout_valid <= dv_n;
            frame_done <= fd_n;
            sync_err   <= se_n;
        end
    end

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        word_n   = word_cnt;
        dout_n   = dout;
        locked_n = locked;
        dv_n     = 1'b0;
        fd_n     = 1'b0;
        se_n     = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (fill_ok && match) begin
                        state_n  = PAYLOAD;
                        locked_n = 1'b1;
                        bit_n    = '0;
                        word_n   = '0;
                    end
                end
                PAYLOAD: begin
                    if (last_bit) begin
                        bit_n  = '0;
                        dout_n = nxt;
                        dv_n   = 1'b1;
                        if (word_cnt == CW'(PAYLOAD_LEN - 1)) begin
                            fd_n    = 1'b1;
                            state_n = CHECK;
                        end else begin
                            word_n = word_cnt + CW'(1);
                        end
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end
                CHECK: begin
                    if (last_bit) begin
                        bit_n = '0;
                        if (match) begin
                            state_n = PAYLOAD;
                            word_n  = '0;
                        end else begin
                            // sr keeps its contents so the hunt resumes on the very next bit
                            se_n     = 1'b1;
                            locked_n = 1'b0;
                            state_n  = HUNT;
                        end
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_word_framer.sv
// Scoreboard bench for serial_word_framer: expected payload words are queued as they are
// sent and matched against dout_valid strobes; lock/error timing is checked inline.
module tb_serial_word_framer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, frame_done, locked, sync_err;
    logic       en_q = 1'b0;

    typedef struct {
        logic [7:0] w;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    serial_word_framer #(.WIDTH(8), .SYNC_WORD(8'hA5), .PAYLOAD_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .dout(dout),
        .dout_valid(dout_valid), .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_q <= en;

    // Scoreboard side: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (dout_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word got=%h", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e.w || frame_done !== e.last) begin
                        failures++;
                        $display("FAIL word got=%h/fd=%b want=%h/fd=%b", dout, frame_done, e.w, e.last);
                    end
                end
            end else if (frame_done) begin
                checks++;
                failures++;
                $display("FAIL frame_done_without_valid got=1 want=0");
            end
            if (!en_q) begin
                checks++;
                if ({dout_valid, frame_done, sync_err} !== 3'b000) begin
                    failures++;
                    $display("FAIL strobe_on_idle got=%b want=000", {dout_valid, frame_done, sync_err});
                end
            end
        end
    end

    task automatic step(input logic b, input logic e);
        din = b;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic gap);
        for (int i = 0; i < 8; i++) begin
            step(w[7-i], 1'b1);
            if (gap) step(1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic push(input logic [7:0] w, input logic last);
        exp_t e;
        e.w = w;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        din = 1'b0;
        #2;
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] s;
        s = 8'hA5;
        checks++;
        if ({dout, dout_valid, frame_done, locked, sync_err} !== 12'h000) begin
            failures++;
            $display("FAIL reset_state got=%h", {dout, dout_valid, frame_done, locked, sync_err});
        end
        do_reset();
        send_word(8'hA5, 1'b0);
        push(8'h11, 1'b0);
        send_word(8'h11, 1'b0);
        for (int i = 0; i < 4; i++) step(s[7-i], 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00 || {locked, dout_valid, frame_done, sync_err} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset got dout=%h flags=%b want 00/0000", dout,
                     {locked, dout_valid, frame_done, sync_err});
        end
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            step(s[7-i], 1'b1);
            checks++;
            if (locked !== (i == 7)) begin
                failures++;
                $display("FAIL relock_after_reset edge=%0d got=%b want=%b", i + 1, locked, i == 7);
            end
        end
    endtask

    task automatic test_clean_frame();
        logic [7:0] pl[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_reset();
        send_word(8'hA5, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL clean_lock got=%b want=1", locked);
        end
        // two back-to-back frames, each followed by a good trailer
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) push(pl[f*4+k], k == 3);
            for (int k = 0; k < 4; k++) send_word(pl[f*4+k], 1'b0);
            send_word(8'hA5, 1'b0);
            checks++;
            if (sync_err !== 1'b0 || locked !== 1'b1) begin
                failures++;
                $display("FAIL clean_trailer got err=%b lock=%b want 0/1", sync_err, locked);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL clean_missing got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_misalign();
        logic [7:0] s;
        s = 8'hA5;
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(s[7-i], 1'b1);
            checks++;
            if (locked !== (i == 7)) begin
                failures++;
                $display("FAIL misalign_lock edge=%0d got=%b want=%b", i + 4, locked, i == 7);
            end
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(s[7-i], 1'b1);
            checks++;
            if (locked !== (i == 7)) begin
                failures++;
                $display("FAIL fill_guard edge=%0d got=%b want=%b", i + 1, locked, i == 7);
            end
        end
    endtask

    task automatic test_bad_trailer();
        logic [7:0] bad, s;
        bad = 8'h5A;
        s = 8'hA5;
        do_reset();
        send_word(8'hA5, 1'b0);
        push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b1);
        send_word(8'h11, 1'b0); send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0); send_word(8'h44, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(bad[7-i], 1'b1);
            checks++;
            if (sync_err !== (i == 7) || locked !== (i != 7)) begin
                failures++;
                $display("FAIL bad_trailer bit=%0d got err=%b lock=%b want %b/%b", i, sync_err,
                         locked, i == 7, i != 7);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(s[7-i], 1'b1);
            checks++;
            if (locked !== (i == 7) || sync_err !== 1'b0) begin
                failures++;
                $display("FAIL rehunt edge=%0d got lock=%b err=%b want %b/0", 49 + i, locked,
                         sync_err, i == 7);
            end
        end
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b1);
        send_word(8'h01, 1'b0); send_word(8'h02, 1'b0);
        send_word(8'h03, 1'b0); send_word(8'h04, 1'b0);
        send_word(8'hA5, 1'b0);
        checks++;
        if (exp_q.size() != 0 || sync_err !== 1'b0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL relock_frame got left=%0d err=%b lock=%b want 0/0/1", exp_q.size(),
                     sync_err, locked);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        send_word(8'hA5, 1'b1);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL gap_lock got=%b want=1", locked);
        end
        push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b1);
        send_word(8'h11, 1'b1); send_word(8'h22, 1'b1);
        send_word(8'h33, 1'b1); send_word(8'h44, 1'b1);
        send_word(8'hA5, 1'b1);
        checks++;
        if (exp_q.size() != 0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL gap_frame got left=%0d lock=%b want 0/1", exp_q.size(), locked);
        end
    endtask

    task automatic test_sync_in_payload();
        do_reset();
        send_word(8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) push(8'hA5, k == 3);
        for (int k = 0; k < 4; k++) begin
            send_word(8'hA5, 1'b0);
            checks++;
            if (sync_err !== 1'b0 || locked !== 1'b1) begin
                failures++;
                $display("FAIL sync_payload word=%0d got err=%b lock=%b want 0/1", k, sync_err, locked);
            end
        end
        send_word(8'hA5, 1'b0);
        checks++;
        if (exp_q.size() != 0 || sync_err !== 1'b0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL sync_payload_trailer got left=%0d err=%b lock=%b want 0/0/1",
                     exp_q.size(), sync_err, locked);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_clean_frame();
        test_misalign();
        test_bad_trailer();
        test_gaps();
        test_sync_in_payload();
        step(1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
